// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, forwarding-select codes and the stall counter width.
package hazard_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam int STALL_CNT_W = 16;

    // The younger (MEM) producer always wins over the older (WB) one.
    function automatic logic [1:0] fwd_select(input logic hit_mem, input logic hit_wb);
        if (hit_mem) begin
            return FWD_MEM;
        end else if (hit_wb) begin
            return FWD_WB;
        end else begin
            return FWD_NONE;
        end
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational ALU operand forwarding select from the MEM and WB stages.
// Register 0 is never forwarded.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    logic mem_ok_s;
    logic wb_ok_s;

    assign mem_ok_s = mem_regwrite && (mem_rd != {REG_W{1'b0}});
    assign wb_ok_s  = wb_regwrite  && (wb_rd  != {REG_W{1'b0}});

    assign fwd_a = fwd_select(mem_ok_s && (mem_rd == ex_rs), wb_ok_s && (wb_rd == ex_rs));
    assign fwd_b = fwd_select(mem_ok_s && (mem_rd == ex_rt), wb_ok_s && (wb_rd == ex_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, data stall.
// Define HAZARD_FWD_EN to enable operand forwarding (narrower data stall).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [REG_W-1:0]       ex_rs,
    input  logic [REG_W-1:0]       ex_rt,
    input  logic [REG_W-1:0]       ex_rd,
    input  logic                   ex_regwrite,
    input  logic                   ex_memread,
    input  logic                   ex_branch_taken,
    input  logic [REG_W-1:0]       mem_rd,
    input  logic [REG_W-1:0]       wb_rd,
    input  logic                   mem_regwrite,
    input  logic                   wb_regwrite,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   hold_pc,
    output logic                   hold_ifid,
    output logic                   clear_ifid,
    output logic                   hold_idex,
    output logic                   clear_idex,
    output logic                   hold_exmem,
    output logic                   clear_exmem,
    output logic                   hold_memwb,
    output logic                   clear_memwb,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e                   state_q, state_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic                     mem_err_q;

    logic timeout_hit_s;
    logic freeze_s;
    logic load_use_s;
    logic data_stall_s;
    logic stall_inc_s;

    function automatic logic src_hit(input logic [REG_W-1:0] rd, input logic wr);
        return wr && (rd != {REG_W{1'b0}}) &&
               ((id_uses_rs && (id_rs == rd)) || (id_uses_rt && (id_rt == rd)));
    endfunction

    assign timeout_hit_s = (state_q == ST_MEM_WAIT) && (wait_q == WAIT_W'(TIMEOUT));
    assign freeze_s      = ((state_q == ST_RUN) && mem_req && !mem_ready) ||
                           ((state_q == ST_MEM_WAIT) && !mem_ready && !timeout_hit_s);
    assign load_use_s    = ex_memread && src_hit(ex_rd, ex_regwrite);

`ifdef HAZARD_FWD_EN
    assign data_stall_s = load_use_s;

    hazard_fwd_unit #(.REG_W(REG_W)) u_fwd (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_rd       (mem_rd),
        .wb_rd        (wb_rd),
        .mem_regwrite (mem_regwrite),
        .wb_regwrite  (wb_regwrite),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );
`else
    // Without forwarding every in-flight producer ahead of WB must be waited out.
    logic unused_s;
    assign unused_s     = ^{ex_rs, ex_rt, wb_rd, wb_regwrite};
    assign data_stall_s = load_use_s || src_hit(ex_rd, ex_regwrite) ||
                          src_hit(mem_rd, mem_regwrite);
    assign fwd_a        = FWD_NONE;
    assign fwd_b        = FWD_NONE;
`endif

    assign stall_inc_s = freeze_s || (data_stall_s && !ex_branch_taken);

    // Next-state logic for the memory-wait FSM, wait counter and stall counter.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = {WAIT_W{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready || timeout_hit_s) begin
                    state_d = ST_RUN;
                    wait_d  = {WAIT_W{1'b0}};
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = {WAIT_W{1'b0}};
            end
        endcase
        if (stall_inc_s && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, counters and the one-cycle timeout pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_q      <= {WAIT_W{1'b0}};
            stall_cnt_q <= {STALL_CNT_W{1'b0}};
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= timeout_hit_s;
        end
    end

    // Pipeline hold/clear controls; priority is freeze > flush > data stall.
    always_comb begin
        hold_pc     = 1'b0;
        hold_ifid   = 1'b0;
        clear_ifid  = 1'b0;
        hold_idex   = 1'b0;
        clear_idex  = 1'b0;
        hold_exmem  = 1'b0;
        clear_exmem = 1'b0;
        hold_memwb  = 1'b0;
        clear_memwb = 1'b0;
        if (!rst_n) begin
            clear_ifid  = 1'b1;
            clear_idex  = 1'b1;
            clear_exmem = 1'b1;
            clear_memwb = 1'b1;
        end else if (freeze_s) begin
            hold_pc     = 1'b1;
            hold_ifid   = 1'b1;
            hold_idex   = 1'b1;
            hold_exmem  = 1'b1;
            clear_memwb = 1'b1;
        end else if (ex_branch_taken) begin
            clear_ifid  = 1'b1;
            clear_idex  = 1'b1;
        end else if (data_stall_s) begin
            hold_pc     = 1'b1;
            hold_ifid   = 1'b1;
            clear_idex  = 1'b1;
        end else begin
            hold_pc     = 1'b0;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default and TIMEOUT=4 instances).
module tb_hazard_ctrl;
    import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {hold_pc, hold_ifid, clear_ifid, hold_idex, clear_idex,
    //  hold_exmem, clear_exmem, hold_memwb, clear_memwb}
    localparam logic [8:0] C_NONE   = 9'b000000000;
    localparam logic [8:0] C_RESET  = 9'b001010101;
    localparam logic [8:0] C_FREEZE = 9'b110101001;
    localparam logic [8:0] C_BRANCH = 9'b001010000;
    localparam logic [8:0] C_STALL  = 9'b110010000;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs, id_uses_rt, ex_regwrite, ex_memread, ex_branch_taken;
    logic mem_regwrite, wb_regwrite, mem_req, mem_ready;

    logic [8:0] ctl, ctl2;
    logic [1:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic mem_err, mem_err2;
    logic [15:0] stall_cnt, stall_cnt2;
    logic h0, h1, c1, h2, c2, h3, c3, h4, c4;
    logic g0, g1, d1, g2, d2, g3, d3, g4, d4;

    int n_checks = 0;
    int n_errors = 0;
    int exp_stall = 0;

    assign ctl  = {h0, h1, c1, h2, c2, h3, c3, h4, c4};
    assign ctl2 = {g0, g1, d1, g2, d2, g3, d3, g4, d4};

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .hold_pc(h0), .hold_ifid(h1), .clear_ifid(c1), .hold_idex(h2), .clear_idex(c2),
        .hold_exmem(h3), .clear_exmem(c3), .hold_memwb(h4), .clear_memwb(c4),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .hold_pc(g0), .hold_ifid(g1), .clear_ifid(d1), .hold_idex(g2), .clear_idex(d2),
        .hold_exmem(g3), .clear_exmem(d3), .hold_memwb(g4), .clear_memwb(d4),
        .fwd_a(fwd_a2), .fwd_b(fwd_b2), .mem_err(mem_err2), .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
        mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_ctl", 32'(ctl), 32'(C_RESET));
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_mem_err", 32'(mem_err), 32'd0);
        rst_n = 1'b1;
        #2;
        chk("idle_ctl", 32'(ctl), 32'(C_NONE));
        chk("idle_fwd_a", 32'(fwd_a), 32'(FWD_NONE));
        tick();

        // Load-use hazard: one bubble.
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #2 chk("loaduse_ctl", 32'(ctl), 32'(C_STALL));
        tick(); exp_stall++;
        idle_inputs();
        #2 chk("loaduse_after_ctl", 32'(ctl), 32'(C_NONE));
        chk("loaduse_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // Register 0 and unused sources never stall.
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #2 chk("r0_ctl", 32'(ctl), 32'(C_NONE));
        ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
        #2 chk("unused_rt_ctl", 32'(ctl), 32'(C_NONE));
        tick();

        // ALU producer in EX: stalls only without forwarding.
        idle_inputs();
        ex_regwrite = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
        #2 chk("ex_alu_ctl", 32'(ctl), 32'(FWD ? C_NONE : C_STALL));
        tick(); exp_stall += FWD ? 0 : 1;
        idle_inputs();
        mem_regwrite = 1'b1; mem_rd = 5'd7; id_rs = 5'd7; id_uses_rs = 1'b1;
        #2 chk("mem_prod_ctl", 32'(ctl), 32'(FWD ? C_NONE : C_STALL));
        tick(); exp_stall += FWD ? 0 : 1;
        idle_inputs();
        wb_regwrite = 1'b1; wb_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
        #2 chk("wb_prod_ctl", 32'(ctl), 32'(C_NONE));
        chk("wb_prod_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // Forwarding selects.
        idle_inputs();
        mem_rd = 5'd5; wb_rd = 5'd5; ex_rs = 5'd5; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        #2 chk("fwd_a_mem", 32'(fwd_a), 32'(FWD ? FWD_MEM : FWD_NONE));
        mem_regwrite = 1'b0;
        #2 chk("fwd_a_wb", 32'(fwd_a), 32'(FWD ? FWD_WB : FWD_NONE));
        ex_rs = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b1;
        #2 chk("fwd_a_r0", 32'(fwd_a), 32'(FWD_NONE));
        ex_rt = 5'd6; mem_rd = 5'd6; wb_rd = 5'd6;
        #2 chk("fwd_b_mem", 32'(fwd_b), 32'(FWD ? FWD_MEM : FWD_NONE));
        tick();

        // Branch flush beats a data stall and does not count.
        idle_inputs();
        ex_branch_taken = 1'b1;
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #2 chk("branch_ctl", 32'(ctl), 32'(C_BRANCH));
        tick();
        idle_inputs();
        #2 chk("branch_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // Memory wait: three frozen cycles, then release.
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2 chk($sformatf("memwait_ctl%0d", i), 32'(ctl), 32'(C_FREEZE));
            tick(); exp_stall++;
        end
        mem_ready = 1'b1;
        #2 chk("memwait_release_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        #2 chk("memwait_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        chk("memwait_state", 32'(dut.state_q), 32'(ST_RUN));

        // Branch arriving during a freeze is deferred until release.
        mem_req = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2 chk($sformatf("brfreeze_ctl%0d", i), 32'(ctl), 32'(C_FREEZE));
            tick(); exp_stall++;
        end
        mem_ready = 1'b1;
        #2 chk("brfreeze_release_ctl", 32'(ctl), 32'(C_BRANCH));
        tick();
        idle_inputs();
        #2 chk("brfreeze_after_ctl", 32'(ctl), 32'(C_NONE));
        chk("brfreeze_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // Reset in the middle of a memory wait.
        mem_req = 1'b1;
        tick();
        tick();
        chk("rst_mid_state_pre", 32'(dut.state_q), 32'(ST_MEM_WAIT));
        rst_n = 1'b0;
        #2 chk("rst_mid_ctl", 32'(ctl), 32'(C_RESET));
        tick();
        rst_n = 1'b1; mem_req = 1'b0;
        #2 chk("rst_mid_state", 32'(dut.state_q), 32'(ST_RUN));
        chk("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_mid_mem_err", 32'(mem_err), 32'd0);
        tick();
        chk("rst_mid_mem_err_next", 32'(mem_err), 32'd0);

        // Timeout on the TIMEOUT=4 instance: 1 RUN + 4 MEM_WAIT frozen cycles.
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2 chk($sformatf("timeout_ctl%0d", i), 32'(ctl2), 32'(C_FREEZE));
            chk($sformatf("timeout_err_lo%0d", i), 32'(mem_err2), 32'd0);
            tick();
        end
        #2 chk("timeout_hit_ctl", 32'(ctl2), 32'(C_NONE));
        mem_req = 1'b0;
        tick();
        chk("timeout_mem_err", 32'(mem_err2), 32'd1);
        chk("timeout_state", 32'(dut_to.state_q), 32'(ST_RUN));
        chk("timeout_stall_cnt", 32'(stall_cnt2), 32'd5);
        tick();
        chk("timeout_mem_err_pulse", 32'(mem_err2), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
